// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses INC times per DEN clocks
// using a Bresenham accumulator, with a shared base-period phase counter.
module clken_gen #(
  parameter int unsigned NCH = 2,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned DEN = 25,
  parameter logic [NCH*ACC_W-1:0] INC_INIT = {8'd6, 8'd8},
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_clr,
  output logic             cfg_err,
  output logic [NCH-1:0]   en,
  output logic [NCH-1:0]   en_d,
  output logic             period_start,
  output logic [ACC_W-1:0] phase
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W:0]   DEN_S = SUM_W'(DEN);
  localparam logic [ACC_W-1:0] DEN_V = ACC_W'(DEN);
  localparam logic [ACC_W-1:0] LAST  = ACC_W'(DEN - 1);
  localparam logic [ACC_W-1:0] ONE   = ACC_W'(1);

  logic [ACC_W-1:0] acc      [NCH];
  logic [ACC_W-1:0] inc      [NCH];
  logic [ACC_W-1:0] init_inc [NCH];
  logic [ACC_W:0]   sum      [NCH];
  logic [ACC_W-1:0] acc_next [NCH];
  logic [NCH-1:0]   hit;
  logic [ACC_W-1:0] phase_next;
  logic             wr_ok;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // Oversized reset increments are clamped so a channel can never exceed one pulse per clock.
      init_inc[i] = (INC_INIT[i*ACC_W +: ACC_W] > DEN_V) ? DEN_V : INC_INIT[i*ACC_W +: ACC_W];
      sum[i]      = {1'b0, acc[i]} + {1'b0, inc[i]};
      hit[i]      = (sum[i] >= DEN_S);
      acc_next[i] = hit[i] ? ACC_W'(sum[i] - DEN_S) : sum[i][ACC_W-1:0];
    end
    phase_next = (phase == LAST) ? '0 : phase + ONE;
    wr_ok      = ({1'b0, cfg_inc} <= DEN_S) && (32'(cfg_ch) < NCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        inc[i] <= init_inc[i];
      end
      en           <= '0;
      en_d         <= '0;
      period_start <= 1'b0;
      phase        <= '0;
      cfg_err      <= 1'b0;
    end else begin
      en_d    <= en;
      cfg_err <= cfg_we & ~wr_ok;
      if (cfg_clr) begin
        for (int i = 0; i < NCH; i++) acc[i] <= '0;
        phase        <= '0;
        en           <= '0;
        period_start <= 1'b1;
      end else if (hold) begin
        en           <= '0;
        period_start <= 1'b0;
      end else begin
        for (int i = 0; i < NCH; i++) acc[i] <= acc_next[i];
        en           <= hit;
        phase        <= phase_next;
        period_start <= (phase_next == '0);
      end
      // The sum above used the old increment; the new one takes effect from the next edge.
      if (cfg_we && wr_ok) inc[cfg_ch] <= cfg_inc;
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Randomized and directed bench for clken_gen; the reference tracks the total accumulated
// increment per channel and pulses whenever that total crosses a multiple of DEN.
module tb_clken_gen;

  localparam int NCH = 2;
  localparam int DEN = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic       cfg_clr = 1'b0;
  logic       cfg_err;
  logic [1:0] en;
  logic [1:0] en_d;
  logic       period_start;
  logic [7:0] phase;

  clken_gen dut (
    .clk(clk), .reset(reset), .hold(hold), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_clr(cfg_clr), .cfg_err(cfg_err), .en(en), .en_d(en_d),
    .period_start(period_start), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: tot_m is the unbounded running sum of increments since the last realign.
  int       tot_m [NCH];
  int       inc_m [NCH];
  bit [1:0] en_m, en_d_m;
  int       step_m;
  bit       ps_m, err_m;

  always @(posedge clk) begin : model
    bit ok;
    ok = (int'(cfg_inc) <= DEN) && (int'(cfg_ch) < NCH);
    if (reset) begin
      for (int i = 0; i < NCH; i++) tot_m[i] <= 0;
      inc_m[0] <= 8;
      inc_m[1] <= 6;
      en_m <= '0;
      en_d_m <= '0;
      step_m <= 0;
      ps_m <= 1'b0;
      err_m <= 1'b0;
    end else begin
      en_d_m <= en_m;
      err_m <= cfg_we && !ok;
      if (cfg_clr) begin
        for (int i = 0; i < NCH; i++) tot_m[i] <= 0;
        step_m <= 0;
        en_m <= '0;
        ps_m <= 1'b1;
      end else if (hold) begin
        en_m <= '0;
        ps_m <= 1'b0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          en_m[i] <= ((tot_m[i] + inc_m[i]) / DEN) != (tot_m[i] / DEN);
          tot_m[i] <= tot_m[i] + inc_m[i];
        end
        step_m <= step_m + 1;
        ps_m <= ((step_m + 1) % DEN) == 0;
      end
      if (cfg_we && ok) inc_m[cfg_ch] <= int'(cfg_inc);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("en", int'(en), int'(en_m));
      check("en_d", int'(en_d), int'(en_d_m));
      check("phase", int'(phase), step_m % DEN);
      check("period_start", int'(period_start), int'(ps_m));
      check("cfg_err", int'(cfg_err), int'(err_m));
    end
  end

  task automatic write(input int ch, input int val);
    cfg_we = 1'b1;
    cfg_ch = 1'(ch);
    cfg_inc = 8'(val);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_phase(input int target);
    int n = 0;
    while (int'(phase) != target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wait_phase", int'(phase), target);
  endtask

  task automatic first_pulse(input int ch, output int k);
    k = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (en[ch]) begin
        k = n;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0, c1, cps, first0, first1, last0, gap0, k;
    repeat (3) @(negedge clk);
    check("rst_en", int'(en), 0);
    check("rst_en_d", int'(en_d), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_err", int'(cfg_err), 0);
    chk_on = 1'b1;
    reset = 1'b0;

    // Defaults over 250 clocks.
    c0 = 0; c1 = 0; cps = 0; first0 = 0; first1 = 0; last0 = 0; gap0 = 0;
    for (int e = 1; e <= 250; e++) begin
      @(negedge clk);
      if (en[0]) begin
        c0++;
        if (first0 == 0) first0 = e;
        if (last0 != 0 && e - last0 > gap0) gap0 = e - last0;
        last0 = e;
      end
      if (en[1]) begin
        c1++;
        if (first1 == 0) first1 = e;
      end
      if (period_start) cps++;
    end
    check("ch0_count", c0, 80);
    check("ch1_count", c1, 60);
    check("ps_count", cps, 10);
    check("ch0_first", first0, 4);
    check("ch1_first", first1, 5);
    check("ch0_gap_le4", int'(gap0 <= 4), 1);

    // Full-rate then zero-rate on ch0.
    write(0, 25);
    c0 = 0;
    for (int e = 0; e < 50; e++) begin @(negedge clk); if (en[0]) c0++; end
    check("ch0_full", c0, 50);
    write(0, 0);
    c0 = 0;
    for (int e = 0; e < 50; e++) begin @(negedge clk); if (en[0]) c0++; end
    check("ch0_zero", c0, 0);

    // Rejected and accepted writes on ch1.
    write(1, 26);
    check("err_pulse", int'(cfg_err), 1);
    c1 = 0;
    for (int e = 0; e < 25; e++) begin @(negedge clk); if (en[1]) c1++; end
    check("ch1_kept6", c1, 6);
    write(1, 25);
    check("no_err", int'(cfg_err), 0);
    c1 = 0;
    for (int e = 0; e < 25; e++) begin @(negedge clk); if (en[1]) c1++; end
    check("ch1_full", c1, 25);

    // Hold mid-period.
    write(0, 8);
    write(1, 6);
    wait_phase(12);
    hold = 1'b1;
    for (int e = 0; e < 7; e++) begin
      @(negedge clk);
      check("hold_en", int'(en), 0);
      check("hold_ps", int'(period_start), 0);
      check("hold_phase", int'(phase), 12);
    end
    hold = 1'b0;
    repeat (60) @(negedge clk);

    // Realign, then realign combined with a write.
    wait_phase(17);
    cfg_clr = 1'b1;
    @(negedge clk);
    cfg_clr = 1'b0;
    check("clr_phase", int'(phase), 0);
    check("clr_ps", int'(period_start), 1);
    first_pulse(0, k);
    check("clr_first0", k, 4);
    repeat (10) @(negedge clk);
    cfg_clr = 1'b1;
    write(0, 3);
    cfg_clr = 1'b0;
    check("clrwe_phase", int'(phase), 0);
    check("clrwe_ps", int'(period_start), 1);
    first_pulse(0, k);
    check("clrwe_first0", k, 9);

    // Reset mid-operation discards the programmed increment.
    wait_phase(9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_phase", int'(phase), 0);
    check("rst2_en", int'(en), 0);
    check("rst2_ps", int'(period_start), 0);
    first_pulse(0, k);
    check("rst2_first0", k, 4);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      hold = ($urandom_range(0, 99) < 10);
      cfg_clr = ($urandom_range(0, 99) < 3);
      cfg_we = ($urandom_range(0, 99) < 10);
      cfg_ch = 1'($urandom_range(0, 1));
      cfg_inc = 8'($urandom_range(0, 30));
      reset = ($urandom_range(0, 999) < 5);
      @(negedge clk);
    end
    hold = 1'b0; cfg_clr = 1'b0; cfg_we = 1'b0; reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
